// File: rtl/pow2_stream_accumulator_if.sv
// Term-in / result-out handshake bundle for the power-of-two stream accumulator.
interface pow2_stream_accumulator_if #(
  parameter int unsigned IN_EXP_WIDTH = 8,
  parameter int unsigned EXP_WIDTH    = 9,
  parameter int unsigned MANT_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH    = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_EXP_WIDTH-1:0] in_exp;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_WIDTH-1:0]    out_exp;
  logic [MANT_WIDTH-1:0]   out_mant;
  logic [CNT_WIDTH-1:0]    out_count;
  logic                    out_sat;

  modport master (
    output in_valid, in_exp, in_last, out_ready,
    input  in_ready, out_valid, out_exp, out_mant, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_exp, in_last, out_ready,
    output in_ready, out_valid, out_exp, out_mant, out_count, out_sat
  );
endinterface

// File: rtl/pow2_stream_accumulator.sv
// Sums a framed stream of 2^e terms into exponent + truncated normalised fraction,
// one term per cycle, holding the result until the downstream handshake.
module pow2_stream_accumulator #(
  parameter int unsigned IN_EXP_WIDTH = 8,
  parameter int unsigned EXP_WIDTH    = 9,
  parameter int unsigned MANT_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input logic clk,
  input logic rst_n,
  pow2_stream_accumulator_if.slave bus
);

  localparam int unsigned SW = MANT_WIDTH + 2;
  localparam logic [SW-1:0]        Hidden   = SW'(1) << MANT_WIDTH;
  localparam logic [EXP_WIDTH:0]   MantLim  = (EXP_WIDTH + 1)'(MANT_WIDTH);
  localparam logic [EXP_WIDTH:0]   ShiftLim = (EXP_WIDTH + 1)'(MANT_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e                state_q, state_d;
  logic [EXP_WIDTH-1:0]  exp_q, exp_d;
  logic [MANT_WIDTH-1:0] frac_q, frac_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  sat_q, sat_d;

  logic                  accept;
  logic [EXP_WIDTH:0]    e_ext, diff, shamt, exp_new;
  logic [SW-1:0]         sig, addend, sum, sig_sh;
  logic [MANT_WIDTH-1:0] frac_new;
  logic                  unused_sig_sh;

  assign bus.in_ready  = (state_q != StHold);
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_exp   = exp_q;
  assign bus.out_mant  = frac_q;
  assign bus.out_count = count_q;
  assign bus.out_sat   = sat_q;

  assign accept = bus.in_valid && (state_q != StHold);

  // Exponent-difference / shift / overflow-increment datapath.
  always_comb begin
    e_ext    = {{(EXP_WIDTH + 1 - IN_EXP_WIDTH){1'b0}}, bus.in_exp};
    diff     = e_ext - {1'b0, exp_q};
    sig      = {2'b01, frac_q};
    shamt    = '0;
    addend   = '0;
    sum      = '0;
    sig_sh   = '0;
    exp_new  = {1'b0, exp_q};
    frac_new = frac_q;
    if (diff[EXP_WIDTH] || (diff == '0)) begin
      // Term is not larger than the accumulator: align the term's hidden bit.
      shamt  = {1'b0, exp_q} - e_ext;
      addend = (shamt > MantLim) ? '0 : (Hidden >> shamt);
      sum    = sig + addend;
      if (sum[SW-1]) begin
        frac_new = sum[MANT_WIDTH:1];
        exp_new  = {1'b0, exp_q} + (EXP_WIDTH + 1)'(1);
      end else begin
        frac_new = sum[MANT_WIDTH-1:0];
      end
    end else begin
      // Term dominates: shift the accumulator down beneath the new hidden bit.
      shamt    = diff;
      sig_sh   = (shamt > ShiftLim) ? '0 : (sig >> shamt);
      frac_new = sig_sh[MANT_WIDTH-1:0];
      exp_new  = e_ext;
    end
  end

  assign unused_sig_sh = ^sig_sh[SW-1:MANT_WIDTH];

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    frac_d  = frac_q;
    count_d = count_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          exp_d   = e_ext[EXP_WIDTH-1:0];
          frac_d  = '0;
          count_d = CNT_WIDTH'(1);
          sat_d   = 1'b0;
          state_d = bus.in_last ? StHold : StAcc;
        end
      end
      StAcc: begin
        if (accept) begin
          count_d = (count_q == '1) ? count_q : count_q + CNT_WIDTH'(1);
          if (!sat_q) begin
            if (exp_new[EXP_WIDTH]) begin
              exp_d  = '1;
              frac_d = '1;
              sat_d  = 1'b1;
            end else begin
              exp_d  = exp_new[EXP_WIDTH-1:0];
              frac_d = frac_new;
            end
          end
          if (bus.in_last) state_d = StHold;
        end
      end
      StHold: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      exp_q   <= '0;
      frac_q  <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      frac_q  <= frac_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_pow2_stream_accumulator.sv
// Directed bench: frame table with hand-computed results plus hold, saturation,
// backpressure and mid-frame reset sequences.
module tb_pow2_stream_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pow2_stream_accumulator_if #(.IN_EXP_WIDTH(8), .EXP_WIDTH(9), .MANT_WIDTH(8), .CNT_WIDTH(8))
    a_if ();
  pow2_stream_accumulator_if #(.IN_EXP_WIDTH(4), .EXP_WIDTH(4), .MANT_WIDTH(8), .CNT_WIDTH(8))
    b_if ();

  pow2_stream_accumulator #(.IN_EXP_WIDTH(8), .EXP_WIDTH(9), .MANT_WIDTH(8), .CNT_WIDTH(8))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  pow2_stream_accumulator #(.IN_EXP_WIDTH(4), .EXP_WIDTH(4), .MANT_WIDTH(8), .CNT_WIDTH(8))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned     n;
    logic [3:0][7:0] e;      // e[0] is the first term
    logic [8:0]      x_exp;
    logic [7:0]      x_mant;
    logic [7:0]      x_cnt;
    logic            x_sat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one term on DUT A and wait (bounded) for its acceptance.
  task automatic send_a(input logic [7:0] e, input logic last);
    int waitc = 0;
    a_if.in_valid = 1'b1;
    a_if.in_exp   = e;
    a_if.in_last  = last;
    while (!a_if.in_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    if (waitc >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_a_timeout: got in_ready=0, expected 1");
    end
    tick();
    a_if.in_valid = 1'b0;
    a_if.in_last  = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] e, input logic last);
    b_if.in_valid = 1'b1;
    b_if.in_exp   = e;
    b_if.in_last  = last;
    check("b_in_ready", 32'(b_if.in_ready), 1);
    tick();
    b_if.in_valid = 1'b0;
    b_if.in_last  = 1'b0;
  endtask

  task automatic check_a(input string tag, input logic [8:0] x_exp, input logic [7:0] x_mant,
                         input logic [7:0] x_cnt, input logic x_sat);
    check({tag, "_valid"}, 32'(a_if.out_valid), 1);
    check({tag, "_exp"},   32'(a_if.out_exp), 32'(x_exp));
    check({tag, "_mant"},  32'(a_if.out_mant), 32'(x_mant));
    check({tag, "_count"}, 32'(a_if.out_count), 32'(x_cnt));
    check({tag, "_sat"},   32'(a_if.out_sat), 32'(x_sat));
  endtask

  task automatic drain_a();
    a_if.out_ready = 1'b1;
    tick();
    a_if.out_ready = 1'b0;
    check("drain_valid_low", 32'(a_if.out_valid), 0);
  endtask

  initial begin
    a_if.in_valid = 1'b0; a_if.in_exp = '0; a_if.in_last = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_exp = '0; b_if.in_last = 1'b0; b_if.out_ready = 1'b0;

    vecs[0] = '{n: 4, e: {8'd10, 8'd4, 8'd5, 8'd5}, x_exp: 10, x_mant: 20, x_cnt: 4, x_sat: 0};
    vecs[1] = '{n: 2, e: {8'd0, 8'd0, 8'd3, 8'd20}, x_exp: 20, x_mant: 0, x_cnt: 2, x_sat: 0};
    vecs[2] = '{n: 2, e: {8'd0, 8'd0, 8'd20, 8'd3}, x_exp: 20, x_mant: 0, x_cnt: 2, x_sat: 0};
    vecs[3] = '{n: 4, e: {8'd1, 8'd1, 8'd1, 8'd1}, x_exp: 3, x_mant: 0, x_cnt: 4, x_sat: 0};
    vecs[4] = '{n: 3, e: {8'd0, 8'd6, 8'd7, 8'd8}, x_exp: 8, x_mant: 192, x_cnt: 3, x_sat: 0};
    vecs[5] = '{n: 2, e: {8'd0, 8'd0, 8'd255, 8'd0}, x_exp: 255, x_mant: 0, x_cnt: 2, x_sat: 0};
    vecs[6] = '{n: 2, e: {8'd0, 8'd0, 8'd255, 8'd255}, x_exp: 256, x_mant: 0, x_cnt: 2, x_sat: 0};
    vecs[7] = '{n: 1, e: {8'd0, 8'd0, 8'd0, 8'd5}, x_exp: 5, x_mant: 0, x_cnt: 1, x_sat: 0};
    vecs[8] = '{n: 3, e: {8'd0, 8'd9, 8'd9, 8'd9}, x_exp: 10, x_mant: 128, x_cnt: 3, x_sat: 0};

    // Reset state.
    #12;
    check("rst_in_ready", 32'(a_if.in_ready), 1);
    check("rst_out_valid", 32'(a_if.out_valid), 0);
    check("rst_out_exp", 32'(a_if.out_exp), 0);
    check("rst_out_mant", 32'(a_if.out_mant), 0);
    check("rst_out_count", 32'(a_if.out_count), 0);
    check("rst_out_sat", 32'(a_if.out_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single-term frame held across three cycles without out_ready.
    send_a(8'd5, 1'b1);
    check_a("single", 9'd5, 8'd0, 8'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a("hold", 9'd5, 8'd0, 8'd1, 1'b0);
      check("hold_in_ready", 32'(a_if.in_ready), 0);
    end
    drain_a();

    // Intermediate accumulator values of {5, 5, 4, 10}.
    send_a(8'd5, 1'b0);
    send_a(8'd5, 1'b0);
    check("mid1_exp", 32'(a_if.out_exp), 6);
    check("mid1_mant", 32'(a_if.out_mant), 0);
    send_a(8'd4, 1'b0);
    check("mid2_exp", 32'(a_if.out_exp), 6);
    check("mid2_mant", 32'(a_if.out_mant), 64);
    check("mid2_valid", 32'(a_if.out_valid), 0);
    send_a(8'd10, 1'b1);
    check_a("mid_final", 9'd10, 8'd20, 8'd4, 1'b0);
    drain_a();

    // Frame table.
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        send_a(vecs[v].e[i], (i == int'(vecs[v].n) - 1));
      end
      check_a($sformatf("vec%0d", v), vecs[v].x_exp, vecs[v].x_mant, vecs[v].x_cnt,
              vecs[v].x_sat);
      drain_a();
    end

    // 300 terms of 2^0: value 300 = 2^8 * (1 + 44/256), count saturates at 255.
    for (int i = 0; i < 300; i++) send_a(8'd0, (i == 299));
    check_a("cnt_sat", 9'd8, 8'd44, 8'd255, 1'b0);
    drain_a();

    // Exponent saturation on the narrow instance, then a clean frame.
    send_b(4'd15, 1'b0);
    send_b(4'd15, 1'b0);
    send_b(4'd2, 1'b1);
    check("b_valid", 32'(b_if.out_valid), 1);
    check("b_exp", 32'(b_if.out_exp), 15);
    check("b_mant", 32'(b_if.out_mant), 255);
    check("b_sat", 32'(b_if.out_sat), 1);
    check("b_count", 32'(b_if.out_count), 3);
    b_if.out_ready = 1'b1;
    tick();
    b_if.out_ready = 1'b0;
    send_b(4'd1, 1'b1);
    check("b2_exp", 32'(b_if.out_exp), 1);
    check("b2_mant", 32'(b_if.out_mant), 0);
    check("b2_sat", 32'(b_if.out_sat), 0);
    check("b2_count", 32'(b_if.out_count), 1);
    b_if.out_ready = 1'b1;
    tick();
    b_if.out_ready = 1'b0;

    // Backpressure: frame B's first term waits through the hold.
    send_a(8'd2, 1'b0);
    send_a(8'd2, 1'b1);
    a_if.in_valid = 1'b1;
    a_if.in_exp   = 8'd9;
    a_if.in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_in_ready", 32'(a_if.in_ready), 0);
      check_a("bp_hold", 9'd3, 8'd0, 8'd2, 1'b0);
      tick();
    end
    a_if.out_ready = 1'b1;
    check("bp_ready_cycle_in_ready", 32'(a_if.in_ready), 0);
    tick();
    a_if.out_ready = 1'b0;
    check("bp_idle_in_ready", 32'(a_if.in_ready), 1);
    check("bp_idle_valid", 32'(a_if.out_valid), 0);
    tick();
    a_if.in_valid = 1'b0;
    a_if.in_last  = 1'b0;
    check_a("bp_frame_b", 9'd9, 8'd0, 8'd1, 1'b0);
    drain_a();

    // Reset mid-frame discards the partial sum.
    send_a(8'd3, 1'b0);
    send_a(8'd4, 1'b0);
    send_a(8'd5, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(a_if.out_valid), 0);
    check("mrst_count", 32'(a_if.out_count), 0);
    check("mrst_in_ready", 32'(a_if.in_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("mrst_no_spurious", 32'(a_if.out_valid), 0);
    send_a(8'd7, 1'b1);
    check_a("mrst_frame", 9'd7, 8'd0, 8'd1, 1'b0);
    drain_a();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pow2_stream_accumulator.md
# pow2_stream_accumulator

- Sums a framed stream of power-of-two terms (2^e, exponent only) into one floating-point result: exponent plus normalised MANT_WIDTH-bit fraction.
- Accepts one term per cycle using the same exponent-difference / shift / overflow-increment datapath as the two-input first-stage adder.
- Generalised to arbitrary frame length, parametrised widths, valid/ready handshakes, term counting and exponent saturation.
- Sits between the per-element exponent stage and the normalisation/division stage of the pseudo-softmax pipeline.

## Interface

**Parameters**
- IN_EXP_WIDTH, default 8: width of each unsigned input exponent.
- EXP_WIDTH, default 9: width of the accumulator and result exponent; must be ≥ IN_EXP_WIDTH.
- MANT_WIDTH, default 8: fraction bits after the implicit leading 1.
- CNT_WIDTH, default 8: width of the term counter.

**Ports**
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: term present.
- in_ready, output, 1: block accepts a term this cycle.
- in_exp, input, IN_EXP_WIDTH: exponent e of term 2^e, unsigned.
- in_last, input, 1: term is the last of the frame.
- out_valid, output, 1: result held.
- out_ready, input, 1: downstream accepts the result.
- out_exp, output, EXP_WIDTH: result exponent.
- out_mant, output, MANT_WIDTH: result fraction; value = 2^out_exp · (1 + out_mant/2^MANT_WIDTH).
- out_count, output, CNT_WIDTH: number of terms in the frame, saturating.
- out_sat, output, 1: exponent saturated during the frame (sticky per frame).

## Operation

**State machine**
- IDLE: no partial sum; in_ready=1. An accepted term loads acc_exp=e, acc_frac=0, count=1, sat=0. If in_last → HOLD, else → ACC.
- ACC: in_ready=1. An accepted term is added as below and count increments, saturating at 2^CNT_WIDTH−1. If in_last → HOLD.
- HOLD: in_ready=0, out_valid=1, outputs stable. On out_ready → IDLE.

**Accumulate step**
- Definitions: sig = 2^MANT_WIDTH + acc_frac (MANT_WIDTH+1 bits); d = e − acc_exp, computed signed at EXP_WIDTH+1 bits.
- d ≤ 0, k = −d:
  - sum = sig + (2^MANT_WIDTH >> k); the shift yields 0 when k > MANT_WIDTH.
  - If sum ≥ 2^(MANT_WIDTH+1): sig' = sum >> 1 (truncate) and exp' = acc_exp + 1.
  - Otherwise sig' = sum and exp' = acc_exp.
- d > 0:
  - sig' = 2^MANT_WIDTH + (sig >> d); the shift yields 0 when d > MANT_WIDTH+1. This never overflows.
  - exp' = e.
- acc_frac = sig'[MANT_WIDTH-1:0]. All rounding is truncation toward zero.
- Saturation: if exp' > 2^EXP_WIDTH−1, set acc_exp = all ones, acc_frac = all ones, sat = 1. Once sat is set, further terms leave exp and frac unchanged; count still increments.
- Outputs out_exp, out_mant, out_count and out_sat are driven directly from the accumulator registers; their value is only meaningful while out_valid=1.

## Timing

- Reset (asynchronous assert): state=IDLE, in_ready=1, out_valid=0, out_exp=0, out_mant=0, out_count=0, out_sat=0.
- Reset mid-frame or during HOLD discards the partial sum or result; no output is produced.
- Throughput: one term per cycle while in ACC/IDLE. Latency: out_valid rises the cycle after the in_last handshake.
- One bubble per frame: in_ready=0 during every HOLD cycle, including the cycle in which out_ready is accepted.
- A new frame may start in the cycle after the output handshake.
- in_valid with in_ready=0 is ignored; the source must hold the term until it is accepted.
- out_valid stays high and outputs stay stable until out_ready; out_ready while out_valid=0 has no effect.
- in_last is only sampled on an accepted term. A single-term frame is legal.

## Test plan

All scenarios use default parameters unless stated.

1. Reset, then frame {5 (last)} → one cycle later out_valid=1, out_exp=5, out_mant=0, out_count=1, out_sat=0. The result stays held over 3 cycles of out_ready=0.
2. Frame {5, 5, 4, 10 (last)} back-to-back → intermediate (6,0) then (6,64), final out_exp=10, out_mant=20, out_count=4.
3. Frame {20, 3 (last)} → k=17 > MANT_WIDTH, so out_exp=20, out_mant=0. Frame {3, 20 (last)} → d=17 > 9, so out_exp=20, out_mant=0.
4. EXP_WIDTH=4, IN_EXP_WIDTH=4, frame {15, 15, 2 (last)} → out_exp=15, out_mant=255, out_sat=1, out_count=3. The next frame {1 (last)} → out_sat=0.
5. Backpressure: frame A ends while out_ready=0 for 4 cycles and in_valid is held high → in_ready=0 throughout, no term lost. After out_ready, frame B's first term is accepted the next cycle.
6. Assert rst_n low mid-frame after 3 terms, release, then frame {7 (last)} → out_exp=7, out_mant=0, out_count=1, with no spurious earlier out_valid.
